// File: rtl/data_mem_pkg.sv
// Shared constants and FSM state type for the data-memory initiator.
package data_mem_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } mem_ctrl_state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side command/response bus and memory-side strobe bus.
interface data_mem_cmd_if;
    import data_mem_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface data_mem_bus_if;
    import data_mem_pkg::*;

    logic              in_data_mem;
    logic [ADDR_W-1:0] adr_data;
    logic              write_data;
    logic [ADDR_W-1:0] adr_data_write;
    logic [DATA_W-1:0] data_write;
    logic              out_data_mem;
    logic [DATA_W-1:0] data;

    modport master (
        output in_data_mem, adr_data, write_data, adr_data_write, data_write,
        input  out_data_mem, data
    );

    modport slave (
        input  in_data_mem, adr_data, write_data, adr_data_write, data_write,
        output out_data_mem, data
    );
endinterface

// File: rtl/data_mem_ctrl_timer.sv
// Read-wait timer: clear/enable counter with an expiry flag at TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != L_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the enabled cycle whose increment brings the count to TIMEOUT.
    assign o_expired = i_en && (r_count == L_LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store initiator driving data-memory strobes.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = data_mem_pkg::DEPTH,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_cmd_if.slave  cmd,
    data_mem_bus_if.master mem
);
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

    mem_ctrl_state_t r_state;
    mem_ctrl_state_t w_next;

    logic              r_in_data_mem,    w_in_data_mem;
    logic [ADDR_W-1:0] r_adr_data,       w_adr_data;
    logic              r_write_data,     w_write_data;
    logic [ADDR_W-1:0] r_adr_data_write, w_adr_data_write;
    logic [DATA_W-1:0] r_data_write,     w_data_write;
    logic              r_rsp_valid,      w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data,       w_rsp_data;
    logic              r_rsp_err,        w_rsp_err;

    logic w_accept;
    logic w_illegal;
    logic w_expired;
    logic w_tmr_clr;
    logic w_tmr_en;

    assign w_accept  = cmd.cmd_valid && (r_state == IDLE);
    assign w_illegal = ({1'b0, cmd.cmd_addr} >= L_DEPTH);
    assign w_tmr_clr = (r_state == RD_REQ);
    assign w_tmr_en  = (r_state == RD_WAIT) && !mem.out_data_mem;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_illegal)       w_next = RESP;
                    else if (cmd.cmd_we) w_next = WR;
                    else                 w_next = RD_REQ;
                end
            end
            WR:      w_next = RESP;
            RD_REQ:  w_next = RD_WAIT;
            RD_WAIT: begin
                if (mem.out_data_mem || w_expired) w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values for the output flops; strobes default low so each lasts one cycle.
    always_comb begin
        w_in_data_mem    = 1'b0;
        w_write_data     = 1'b0;
        w_adr_data       = r_adr_data;
        w_adr_data_write = r_adr_data_write;
        w_data_write     = r_data_write;
        w_rsp_valid      = (w_next == RESP);
        w_rsp_data       = r_rsp_data;
        w_rsp_err        = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_rsp_err  = 1'b1;
                        w_rsp_data = '0;
                    end else if (cmd.cmd_we) begin
                        w_adr_data_write = cmd.cmd_addr;
                        w_data_write     = cmd.cmd_wdata;
                        w_write_data     = 1'b1;
                        w_rsp_err        = 1'b0;
                    end else begin
                        w_adr_data    = cmd.cmd_addr;
                        w_in_data_mem = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (mem.out_data_mem) begin
                    w_rsp_data = mem.data;
                    w_rsp_err  = 1'b0;
                end else if (w_expired) begin
                    w_rsp_data = '0;
                    w_rsp_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data_mem    <= 1'b0;
            r_adr_data       <= '0;
            r_write_data     <= 1'b0;
            r_adr_data_write <= '0;
            r_data_write     <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_data       <= '0;
            r_rsp_err        <= 1'b0;
        end else begin
            r_in_data_mem    <= w_in_data_mem;
            r_adr_data       <= w_adr_data;
            r_write_data     <= w_write_data;
            r_adr_data_write <= w_adr_data_write;
            r_data_write     <= w_data_write;
            r_rsp_valid      <= w_rsp_valid;
            r_rsp_data       <= w_rsp_data;
            r_rsp_err        <= w_rsp_err;
        end
    end

    assign cmd.cmd_ready      = (r_state == IDLE);
    assign cmd.rsp_valid      = r_rsp_valid;
    assign cmd.rsp_data       = r_rsp_data;
    assign cmd.rsp_err        = r_rsp_err;
    assign mem.in_data_mem    = r_in_data_mem;
    assign mem.adr_data       = r_adr_data;
    assign mem.write_data     = r_write_data;
    assign mem.adr_data_write = r_adr_data_write;
    assign mem.data_write     = r_data_write;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a one-cycle-latency memory model.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        bit                chk_data;
        int                lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_cmd_if cmd ();
    data_mem_bus_if mem ();

    data_mem_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd),
        .mem   (mem)
    );

    // Memory model: answers a read strobe with a pulse one cycle later.
    logic [DATA_W-1:0] ram [DEPTH];
    logic              mem_ack   = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              late_ack  = 1'b0;
    bit                mute      = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= DATA_W'(i + 1);
            mem_ack <= 1'b0;
        end else begin
            mem_ack <= mem.in_data_mem && !mute;
            if (mem.in_data_mem) mem_rdata <= ram[mem.adr_data[3:0]];
            if (mem.write_data)  ram[mem.adr_data_write[3:0]] <= mem.data_write;
        end
    end

    assign mem.out_data_mem = mem_ack | late_ack;
    assign mem.data         = late_ack ? 32'hBAD0BAD0 : mem_rdata;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   busy  = 1'b0;
    exp_t exp_q [$];
    int   acc_q [$];
    int   rd_cnt = 0, wr_cnt = 0, rd_w = 0, wr_w = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Busy model: set at accept, cleared at the edge closing the response cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            acc_q.delete();
        end else begin
            if (busy && cmd.rsp_valid) busy <= 1'b0;
            if (cmd.cmd_valid && cmd.cmd_ready) begin
                busy <= 1'b1;
                acc_q.push_back(cyc);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            chk("cmd_ready", {31'b0, cmd.cmd_ready}, {31'b0, !busy});
            if (cmd.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    chk("rsp_err", {31'b0, cmd.rsp_err}, {31'b0, e.err});
                    if (e.chk_data) chk("rsp_data", cmd.rsp_data, e.data);
                    chk("rsp_latency", 32'(cyc - a), 32'(e.lat));
                end
            end
            if (mem.in_data_mem) begin
                if (rd_w == 0) rd_cnt++;
                rd_w++;
            end else if (rd_w != 0) begin
                chk("rd_strobe_width", 32'(rd_w), 32'd1);
                rd_w = 0;
            end
            if (mem.write_data) begin
                if (wr_w == 0) wr_cnt++;
                wr_w++;
            end else if (wr_w != 0) begin
                chk("wr_strobe_width", 32'(wr_w), 32'd1);
                wr_w = 0;
            end
        end
    end

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        chk("drain_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_accept(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            if (cmd.cmd_ready && rst_n) got = 1'b1;
        end
        chk(name, {31'b0, got}, 32'd1);
    endtask

    task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W-1:0] ed, input logic ee, input bit cd, input int lat);
        exp_t e;
        e.data = ed; e.err = ee; e.chk_data = cd; e.lat = lat;
        exp_q.push_back(e);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_we    = we;
        cmd.cmd_addr  = addr;
        cmd.cmd_wdata = wd;
        wait_accept("accept_timeout");
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        wait_drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_we    = 1'b0;
        cmd.cmd_addr  = '0;
        cmd.cmd_wdata = '0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_in_data_mem", {31'b0, mem.in_data_mem}, 32'd0);
        chk("rst_write_data",  {31'b0, mem.write_data}, 32'd0);
        chk("rst_adr_data",    {27'b0, mem.adr_data}, 32'd0);
        chk("rst_adr_wr",      {27'b0, mem.adr_data_write}, 32'd0);
        chk("rst_data_write",  mem.data_write, 32'd0);
        chk("rst_rsp_valid",   {31'b0, cmd.rsp_valid}, 32'd0);
        chk("rst_rsp_data",    cmd.rsp_data, 32'd0);
        chk("rst_rsp_err",     {31'b0, cmd.rsp_err}, 32'd0);
        chk("rst_cmd_ready",   {31'b0, cmd.cmd_ready}, 32'd1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_strobe", {29'b0, mem.in_data_mem, mem.write_data, cmd.rsp_valid}, 32'd0);
        end

        // Nominal load, store then load-back, illegal address.
        send(1'b0, 5'd2,  32'd0,        32'd3,        1'b0, 1'b1, 3);
        send(1'b1, 5'd5,  32'hDEADBEEF, 32'd0,        1'b0, 1'b0, 2);
        send(1'b0, 5'd5,  32'd0,        32'hDEADBEEF, 1'b0, 1'b1, 3);
        send(1'b0, 5'd16, 32'd0,        32'd0,        1'b1, 1'b1, 1);

        // Memory never answers: 8 wait cycles then error; late pulse ignored.
        mute = 1'b1;
        send(1'b0, 5'd3, 32'd0, 32'd0, 1'b1, 1'b1, 10);
        mute = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_rsp_data", cmd.rsp_data, 32'd0);

        // Three back-to-back loads; reset pulsed during the second's wait.
        e.err = 1'b0; e.chk_data = 1'b1; e.lat = 3;
        e.data = 32'd8;  exp_q.push_back(e);
        e.data = 32'd10; exp_q.push_back(e);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_we    = 1'b0;
        cmd.cmd_addr  = 5'd7;
        wait_accept("accept1_timeout");
        @(negedge clk);
        cmd.cmd_addr = 5'd8;
        wait_accept("accept2_timeout");
        @(negedge clk);
        cmd.cmd_addr = 5'd9;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_accept("accept3_timeout");
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        chk("rd_strobe_count", 32'(rd_cnt), 32'd6);
        chk("wr_strobe_count", 32'(wr_cnt), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
